// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline-stage definitions: bundle widths and control-bit positions.
package pipe_pkg;

    // Per-stage bundle widths
    localparam int unsigned IFID_DATA_W  = 64;  // instruction 32 + PC+4 32
    localparam int unsigned IDEX_CTRL_W  = 9;
    localparam int unsigned EXMEM_CTRL_W = 4;
    localparam int unsigned MEMWB_CTRL_W = 3;
    localparam int unsigned MEMWB_DATA_W = 69;  // ReadData 32 + ALUOut 32 + WriteReg 5

    // Control-bit positions within the MEM/WB control bundle
    localparam int unsigned RW_BIT  = 0;
    localparam int unsigned M2R_BIT = 1;
    localparam int unsigned SYS_BIT = 2;

    // MEM/WB payloads; field order matches the bit indices above
    typedef struct packed {
        logic syscall;
        logic memtoreg;
        logic regwrite;
    } memwb_ctrl_t;

    typedef struct packed {
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
    } memwb_data_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear, used for stall/bubble profiling.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Reset and clear win over counting; stop at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with ready/valid handshake, optional
// 2-entry skid buffer, flush-to-bubble and a bubble-cycle profiling counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = MEMWB_CTRL_W,
    parameter int unsigned DATA_W = MEMWB_DATA_W,
    parameter bit          SKID   = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              clr_cnt
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic              in_xfer;
    logic              out_xfer;

    // A bubble must never drive RegWrite/MemWrite downstream
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
    assign out_data  = main_data;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

    generate
        if (SKID) begin : g_skid
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            // Ready depends only on register state, breaking the upstream ready path
            assign in_ready = ~skid_valid;

            // Main/skid update: reset > flush > drain skid > load main > load skid > drain main
            always_ff @(posedge clk) begin
                if (reset) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    main_data  <= '0;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= '0;
                    skid_data  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    skid_valid <= 1'b0;
                    skid_ctrl  <= '0;
                end else if (out_xfer && skid_valid) begin
                    main_ctrl  <= skid_ctrl;
                    main_data  <= skid_data;
                    skid_valid <= 1'b0;
                end else if (in_xfer && (!main_valid || out_xfer)) begin
                    main_valid <= 1'b1;
                    main_ctrl  <= in_ctrl;
                    main_data  <= in_data;
                end else if (in_xfer) begin
                    skid_valid <= 1'b1;
                    skid_ctrl  <= in_ctrl;
                    skid_data  <= in_data;
                end else if (out_xfer) begin
                    main_valid <= 1'b0;
                end
            end
        end else begin : g_single
            // Accept when empty or when the held entry leaves this cycle
            assign in_ready = out_ready | ~main_valid;

            // Single-entry update: reset > flush > load > drain
            always_ff @(posedge clk) begin
                if (reset) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                    main_data  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    main_ctrl  <= '0;
                end else if (in_xfer) begin
                    main_valid <= 1'b1;
                    main_ctrl  <= in_ctrl;
                    main_data  <= in_data;
                end else if (out_xfer) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Counts every non-reset cycle in which the stage presents a bubble
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (clr_cnt),
        .enable (~main_valid),
        .count  (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (skid, single-register and
// 3-bit-counter variants driven from shared stimulus).
module tb_pipe_stage_reg;

    localparam int unsigned CW = 3;
    localparam int unsigned DW = 69;

    localparam logic [DW-1:0] DATA0 = 69'h1_2345_6789_ABCD_EF01;
    localparam logic [DW-1:0] DA    = 69'h0_AAAA_0000_1111_000A;
    localparam logic [DW-1:0] DB    = 69'h1_BBBB_0000_2222_000B;
    localparam logic [DW-1:0] DC    = 69'h0_CCCC_0000_3333_000C;
    localparam logic [DW-1:0] DD    = 69'h1_DDDD_0000_4444_000D;
    localparam logic [DW-1:0] DE    = 69'h0_EEEE_0000_5555_000E;
    localparam logic [DW-1:0] DF    = 69'h1_FFFF_0000_6666_000F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, flush, in_valid, out_ready, clr_cnt;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          s1_in_ready, s1_out_valid;
    logic [CW-1:0] s1_out_ctrl;
    logic [DW-1:0] s1_out_data;
    logic [15:0]   s1_bubble_cnt;

    logic          s0_in_ready, s0_out_valid;
    logic [CW-1:0] s0_out_ctrl;
    logic [DW-1:0] s0_out_data;
    logic [15:0]   s0_bubble_cnt;

    logic          c3_in_ready, c3_out_valid;
    logic [CW-1:0] c3_out_ctrl;
    logic [DW-1:0] c3_out_data;
    logic [2:0]    c3_bubble_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(16)) dut_s1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s1_out_valid), .out_ready(out_ready),
        .out_ctrl(s1_out_ctrl), .out_data(s1_out_data), .bubble_cnt(s1_bubble_cnt), .clr_cnt(clr_cnt));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CNT_W(16)) dut_s0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s0_out_valid), .out_ready(out_ready),
        .out_ctrl(s0_out_ctrl), .out_data(s0_out_data), .bubble_cnt(s0_bubble_cnt), .clr_cnt(clr_cnt));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(3)) dut_c3 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c3_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c3_out_valid), .out_ready(out_ready),
        .out_ctrl(c3_out_ctrl), .out_data(c3_out_data), .bubble_cnt(c3_bubble_cnt), .clr_cnt(clr_cnt));

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] sdat(input int i);
        return {5'(i), 32'hC0DE_0000 + 32'(i), 32'(i * 7 + 1)};
    endfunction

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
        in_ctrl = '0; in_data = '0;
        tick(); tick();
        checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", s1_out_valid); end
        checks++; if (s1_out_ctrl !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", s1_out_ctrl); end
        checks++; if (s1_out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", s1_out_data); end
        checks++; if (s1_bubble_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", s1_bubble_cnt); end
        reset = 1'b0;
        #1;
        checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", s1_in_ready); end
        tick();
        checks++; if (s1_bubble_cnt !== 16'd1) begin failures++; $display("FAIL reset_first_bubble got=%0d exp=1", s1_bubble_cnt); end
    endtask

    task automatic test_pass_through();
        in_valid = 1'b1; in_ctrl = 3'b101; in_data = DATA0;
        tick();
        checks++; if (s1_out_valid !== 1'b1) begin failures++; $display("FAIL pass_valid got=%b exp=1", s1_out_valid); end
        checks++; if (s1_out_ctrl !== 3'b101) begin failures++; $display("FAIL pass_ctrl got=%b exp=101", s1_out_ctrl); end
        checks++; if (s1_out_data !== DATA0) begin failures++; $display("FAIL pass_data got=%h exp=%h", s1_out_data, DATA0); end
        for (int i = 0; i < 8; i++) begin
            in_ctrl = 3'(i); in_data = sdat(i);
            tick();
            checks++; if (s1_out_valid !== 1'b1 || s1_out_ctrl !== 3'(i)) begin failures++; $display("FAIL stream_valid_ctrl[%0d] got=%b/%b exp=1/%b", i, s1_out_valid, s1_out_ctrl, 3'(i)); end
            checks++; if (s1_out_data !== sdat(i)) begin failures++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, s1_out_data, sdat(i)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 3'b000) begin failures++; $display("FAIL drain got=%b/%b exp=0/000", s1_out_valid, s1_out_ctrl); end
        checks++; if (s1_out_data !== sdat(7)) begin failures++; $display("FAIL drain_hold got=%h exp=%h", s1_out_data, sdat(7)); end
        checks++; if (s1_bubble_cnt !== 16'd2) begin failures++; $display("FAIL stream_no_bubble got=%0d exp=2", s1_bubble_cnt); end
        checks++; if (s0_out_data !== sdat(7)) begin failures++; $display("FAIL s0_stream_data got=%h exp=%h", s0_out_data, sdat(7)); end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b001; in_data = DA;
        tick();
        checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("FAIL stall_ready_a got=%b exp=1", s1_in_ready); end
        in_ctrl = 3'b110; in_data = DB;
        tick();
        checks++; if (s1_in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_b got=%b exp=0", s1_in_ready); end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (s1_out_valid !== 1'b1 || s1_out_ctrl !== 3'b001 || s1_out_data !== DA) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%b/%h exp=1/001/%h", k, s1_out_valid, s1_out_ctrl, s1_out_data, DA); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (s1_out_valid !== 1'b1 || s1_out_data !== DA) begin failures++; $display("FAIL release_a got=%b/%h exp=1/%h", s1_out_valid, s1_out_data, DA); end
        tick();
        checks++; if (s1_out_valid !== 1'b1 || s1_out_ctrl !== 3'b110 || s1_out_data !== DB) begin failures++; $display("FAIL release_b got=%b/%b/%h exp=1/110/%h", s1_out_valid, s1_out_ctrl, s1_out_data, DB); end
        checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", s1_in_ready); end
        tick();
        checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL release_empty got=%b exp=0", s1_out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b001; in_data = DA;
        tick();
        in_ctrl = 3'b110; in_data = DB;
        tick();
        in_ctrl = 3'b111; in_data = DC; flush = 1'b1;
        #1;
        checks++; if (s1_in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready_full got=%b exp=0", s1_in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 3'b000) begin failures++; $display("FAIL flush_full got=%b/%b exp=0/000", s1_out_valid, s1_out_ctrl); end
        checks++; if (s1_out_data !== DA) begin failures++; $display("FAIL flush_data_hold got=%h exp=%h", s1_out_data, DA); end
        checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_after got=%b exp=1", s1_in_ready); end
        // main full, skid empty: C would be accepted but flush drops it
        in_valid = 1'b1; in_ctrl = 3'b001; in_data = DA;
        tick();
        in_ctrl = 3'b111; in_data = DC; flush = 1'b1;
        #1;
        checks++; if (s1_in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_half got=%b exp=1", s1_in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 3'b000) begin failures++; $display("FAIL flush_drop got=%b/%b exp=0/000", s1_out_valid, s1_out_ctrl); end
        out_ready = 1'b1;
        tick();
        checks++; if (s1_out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_c got=%b exp=0", s1_out_valid); end
        in_valid = 1'b1; in_ctrl = 3'b010; in_data = DD;
        tick();
        checks++; if (s1_out_valid !== 1'b1 || s1_out_ctrl !== 3'b010 || s1_out_data !== DD) begin failures++; $display("FAIL flush_then_d got=%b/%b/%h exp=1/010/%h", s1_out_valid, s1_out_ctrl, s1_out_data, DD); end
        in_valid = 1'b0;
        tick();
        checks++; if (s1_out_valid !== 1'b0 || s0_out_valid !== 1'b0) begin failures++; $display("FAIL flush_drain got=%b/%b exp=0/0", s1_out_valid, s0_out_valid); end
    endtask

    task automatic test_skid0_comb();
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("FAIL s0_ready_empty got=%b exp=1", s0_in_ready); end
        in_valid = 1'b1; in_ctrl = 3'b011; in_data = DE;
        tick();
        checks++; if (s0_out_valid !== 1'b1 || s0_out_data !== DE) begin failures++; $display("FAIL s0_load_e got=%b/%h exp=1/%h", s0_out_valid, s0_out_data, DE); end
        checks++; if (s0_in_ready !== 1'b0) begin failures++; $display("FAIL s0_ready_stall got=%b exp=0", s0_in_ready); end
        out_ready = 1'b1; in_ctrl = 3'b100; in_data = DF;
        #1;
        checks++; if (s0_in_ready !== 1'b1) begin failures++; $display("FAIL s0_ready_comb got=%b exp=1", s0_in_ready); end
        tick();
        checks++; if (s0_out_valid !== 1'b1 || s0_out_ctrl !== 3'b100 || s0_out_data !== DF) begin failures++; $display("FAIL s0_replace got=%b/%b/%h exp=1/100/%h", s0_out_valid, s0_out_ctrl, s0_out_data, DF); end
        in_valid = 1'b0;
        tick();
        checks++; if (s0_out_valid !== 1'b0) begin failures++; $display("FAIL s0_drain got=%b exp=0", s0_out_valid); end
    endtask

    task automatic test_bubble_sat();
        logic [2:0] exp_cnt;
        reset = 1'b1;
        tick(); tick();
        checks++; if (c3_bubble_cnt !== 3'd0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", c3_bubble_cnt); end
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_cnt = (k < 7) ? 3'(k) : 3'd7;
            checks++; if (c3_bubble_cnt !== exp_cnt) begin failures++; $display("FAIL cnt_sat[%0d] got=%0d exp=%0d", k, c3_bubble_cnt, exp_cnt); end
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        checks++; if (c3_bubble_cnt !== 3'd0) begin failures++; $display("FAIL cnt_clear got=%0d exp=0", c3_bubble_cnt); end
        tick();
        checks++; if (c3_bubble_cnt !== 3'd1) begin failures++; $display("FAIL cnt_after_clr1 got=%0d exp=1", c3_bubble_cnt); end
        tick();
        checks++; if (c3_bubble_cnt !== 3'd2) begin failures++; $display("FAIL cnt_after_clr2 got=%0d exp=2", c3_bubble_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b001; in_data = DA;
        tick();
        in_ctrl = 3'b110; in_data = DB;
        tick();
        in_valid = 1'b0;
        checks++; if (s1_in_ready !== 1'b0 || s1_out_valid !== 1'b1) begin failures++; $display("FAIL rst_stall_full got=%b/%b exp=0/1", s1_in_ready, s1_out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (s1_out_valid !== 1'b0 || s1_out_ctrl !== 3'b000) begin failures++; $display("FAIL rst_stall_valid got=%b/%b exp=0/000", s1_out_valid, s1_out_ctrl); end
        checks++; if (s1_out_data !== '0) begin failures++; $display("FAIL rst_stall_data got=%h exp=0", s1_out_data); end
        checks++; if (s1_bubble_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", s1_bubble_cnt); end
        tick();
        checks++; if (s1_in_ready !== 1'b1 || s1_out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_after got=%b/%b exp=1/0", s1_in_ready, s1_out_valid); end
        checks++; if (s1_bubble_cnt !== 16'd1) begin failures++; $display("FAIL rst_stall_cnt_after got=%0d exp=1", s1_bubble_cnt); end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_stall_skid();
        test_flush();
        test_skid0_comb();
        test_bubble_sat();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
